hilo_mdu: RTL

- Multi-cycle multiply/divide unit for the E stage of the pipelined MIPS core.
- Owns the HI/LO registers; executes mult/multu/div/divu/mthi/mtlo and serves mfhi/mflo reads.
- Drives the pipeline stall request while an operation is in flight.
- Sits between E-stage operand forwarding (upstream) and the E/M pipeline register (downstream).

---
 rtl/hilo_mdu_pkg.sv | 31 +++
 rtl/hilo_mdu_md_calc.sv | 47 ++++
 rtl/hilo_mdu.sv | 100 ++++++++++
 3 files changed

// File: rtl/hilo_mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, latency defaults,
// read-select encoding and the busy FSM state type.
package hilo_mdu_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   localparam int unsigned MULT_LAT_DEF = 5;
   localparam int unsigned DIV_LAT_DEF  = 10;

   localparam logic HILO_SEL_LO = 1'b0;
   localparam logic HILO_SEL_HI = 1'b1;

   typedef enum logic [0:0] {
      StIdle,
      StRun
   } mdu_state_e;

   function automatic logic is_mult(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/hilo_mdu_md_calc.sv
// Combinational multiply/divide datapath working on the latched operands.
// Returns {hi, lo} for mult*/div* and flags a zero divisor.
module md_calc
   import hilo_mdu_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] res,
   output logic        div_zero
);

   logic [63:0] a_sx, b_sx, prod_s, prod_u;
   logic        sgn_div, neg_a, neg_b;
   logic [31:0] mag_a, mag_b, divisor, uq, ur, quot, rem;

   // Low 64 bits of a product of sign-extended operands equal the signed product.
   assign a_sx   = {{32{a[31]}}, a};
   assign b_sx   = {{32{b[31]}}, b};
   assign prod_s = a_sx * b_sx;
   assign prod_u = {32'd0, a} * {32'd0, b};

   // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
   assign sgn_div = (op == MD_DIV);
   assign neg_a   = sgn_div & a[31];
   assign neg_b   = sgn_div & b[31];
   assign mag_a   = neg_a ? (~a + 32'd1) : a;
   assign mag_b   = neg_b ? (~b + 32'd1) : b;
   assign divisor = (mag_b == 32'd0) ? 32'd1 : mag_b;
   assign uq      = mag_a / divisor;
   assign ur      = mag_a % divisor;
   assign quot    = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
   assign rem     = neg_a ? (~ur + 32'd1) : ur;

   assign div_zero = is_div(op) && (b == 32'd0);

   always_comb begin
      res = 64'd0;
      case (op)
         MD_MULT:         res = prod_s;
         MD_MULTU:        res = prod_u;
         MD_DIV, MD_DIVU: res = {rem, quot};
         default:         res = 64'd0;
      endcase
   end

endmodule

// File: rtl/hilo_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/div for a fixed number of busy
// cycles, handles mthi/mtlo in one cycle and raises the pipeline stall request.
module hilo_mdu
   import hilo_mdu_pkg::*;
#(
   parameter int unsigned MULT_LAT = MULT_LAT_DEF,
   parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        d_md_use,
   input  logic        mf_sel,
   output logic [31:0] hilo_out,
   output logic        busy,
   output logic        stall
);

   localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int unsigned CntW   = $clog2(MaxLat + 1);
   localparam logic [CntW-1:0] MultCnt = CntW'(MULT_LAT);
   localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_LAT);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   mdu_state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q;
   logic [2:0]      op_q;
   logic [31:0]     rs_q, rt_q, hi_q, lo_q;

   logic        accept, accept_long, done, res_we, mthi_we, mtlo_we;
   logic [63:0] calc_res;
   logic        calc_dz;

   md_calc u_md_calc (
      .op       (op_q),
      .a        (rs_q),
      .b        (rt_q),
      .res      (calc_res),
      .div_zero (calc_dz)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (accept_long) state_d = StRun;
         StRun:  if (done)        state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs and write strobes
   always_comb begin
      busy        = (state_q == StRun);
      accept      = start & ~busy;
      accept_long = accept & (is_mult(md_op) | is_div(md_op));
      done        = busy & (cnt_q == CntOne);
      res_we      = done & ~calc_dz;
      mthi_we     = accept & (md_op == MD_MTHI);
      mtlo_we     = accept & (md_op == MD_MTLO);
      stall       = d_md_use & (start | busy);
      hilo_out    = (mf_sel == HILO_SEL_HI) ? hi_q : lo_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         op_q  <= '0;
         rs_q  <= '0;
         rt_q  <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         if (accept_long) begin
            cnt_q <= is_mult(md_op) ? MultCnt : DivCnt;
            op_q  <= md_op;
            rs_q  <= rs_data;
            rt_q  <= rt_data;
         end else if (busy) begin
            cnt_q <= cnt_q - CntOne;
         end
         if (res_we) begin
            hi_q <= calc_res[63:32];
            lo_q <= calc_res[31:0];
         end
         if (mthi_we) hi_q <= rs_data;
         if (mtlo_we) lo_q <= rs_data;
      end
   end

endmodule
